// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline control unit and the stage registers
// Signals: stallreq_id/ex/mem, flush_req, flush_pc (stage -> control);
//          stall[5:0], flush, new_pc, busy, stall_cnt, stall_timeout (control -> stages)
interface pipe_ctrl_if #(parameter int CNT_W = 8);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_timeout;
    modport master (
        input  stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
        output stall, flush, new_pc, busy, stall_cnt, stall_timeout
    );
    modport slave (
        output stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
        input  stall, flush, new_pc, busy, stall_cnt, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, sequences flush/refill, tracks stall duration
// Ports: clk, rst (async, active-high); bus (pipe_ctrl_if.master) carries the stall
//        requests and flush request in, and the stall vector, flush pulse, restart pc,
//        busy flag, stall counter and sticky timeout out.
module pipe_ctrl #(
    parameter int STALL_LIMIT   = 255,
    parameter int CNT_W         = 8,
    parameter int REFILL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master bus
);
    localparam int RW = $clog2(REFILL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, REFILL} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    refill_q, refill_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [5:0]       stall;

    // Highest stalled stage wins; everything upstream of it holds too.
    assign stall = (state_q == FLUSH) ? 6'b000000 :
                   bus.stallreq_mem   ? 6'b011111 :
                   bus.stallreq_ex    ? 6'b001111 :
                   bus.stallreq_id    ? 6'b000111 : 6'b000000;

    // A new flush request overrides whatever the machine is doing.
    always_comb begin
        state_d  = state_q;
        refill_d = refill_q;
        new_pc_d = new_pc_q;
        if (bus.flush_req) begin
            state_d  = FLUSH;
            new_pc_d = bus.flush_pc;
        end else if (state_q == FLUSH) begin
            state_d  = REFILL;
            refill_d = RW'(REFILL_CYCLES - 1);
        end else if (state_q == REFILL) begin
            if (refill_q == '0) state_d = IDLE;
            else refill_d = refill_q - RW'(1);
        end
    end

    always_comb begin
        cnt_d     = (stall == '0) ? '0 : (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        timeout_d = timeout_q | ((stall != '0) && (cnt_d == CNT_W'(STALL_LIMIT)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            refill_q  <= '0;
            new_pc_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            refill_q  <= refill_d;
            new_pc_q  <= new_pc_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.stall         = stall;
    assign bus.flush         = (state_q == FLUSH);
    assign bus.new_pc        = new_pc_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.stall_cnt     = cnt_q;
    assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a cycle-count model
module tb_pipe_ctrl;
    localparam int LIM  = 10;
    localparam int CW   = 4;
    localparam int RC   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 1'b0;

    // Model: cycles since the last accepted flush request (0 = flush cycle),
    // length of the current stall run, captured pc, sticky timeout.
    int          m_since = 1000;
    int          m_run   = 0;
    logic [31:0] m_pc    = '0;
    logic        m_to    = 1'b0;

    pipe_ctrl_if #(.CNT_W(CW)) bus();

    pipe_ctrl #(.STALL_LIMIT(LIM), .CNT_W(CW), .REFILL_CYCLES(RC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_stall();
        if (m_since == 0) return 6'b000000;
        if (bus.stallreq_mem) return 6'b011111;
        if (bus.stallreq_ex) return 6'b001111;
        if (bus.stallreq_id) return 6'b000111;
        return 6'b000000;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_since = 1000;
            m_run   = 0;
            m_pc    = '0;
            m_to    = 1'b0;
        end else begin
            m_run = (exp_stall() != 0) ? ((m_run < MAXC) ? m_run + 1 : MAXC) : 0;
            if (m_run == LIM) m_to = 1'b1;
            if (bus.flush_req) begin
                m_since = 0;
                m_pc    = bus.flush_pc;
            end else if (m_since < 1000) m_since++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && cmp_en) begin
            check("m_stall", bus.stall, exp_stall());
            check("m_flush", bus.flush, m_since == 0);
            check("m_busy", bus.busy, m_since <= RC);
            check("m_cnt", bus.stall_cnt, m_run);
            check("m_timeout", bus.stall_timeout, m_to);
            check("m_new_pc", bus.new_pc, m_pc);
        end
    end

    task automatic drive(input bit id, input bit ex, input bit mem, input bit fr, input logic [31:0] pc);
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.stallreq_mem = mem;
        bus.flush_req    = fr;
        bus.flush_pc     = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycles(input int n);
        repeat (n) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom);
            tick();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        #12 rst = 1'b0;
        check("rst_stall", bus.stall, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cnt", bus.stall_cnt, 0);
        check("rst_new_pc", bus.new_pc, 0);
        check("rst_timeout", bus.stall_timeout, 0);
        cmp_en = 1'b1;
        tick();
        drive(1, 0, 0, 0, 0); #1 check("stall_id", bus.stall, 6'b000111); tick();
        drive(0, 1, 0, 0, 0); #1 check("stall_ex", bus.stall, 6'b001111); tick();
        drive(0, 0, 1, 0, 0); #1 check("stall_mem", bus.stall, 6'b011111); tick();
        drive(1, 1, 1, 0, 0); #1 check("stall_all", bus.stall, 6'b011111); tick();
        check("cnt_four", bus.stall_cnt, 4);
        drive(0, 0, 0, 0, 0); tick();
        check("cnt_clear", bus.stall_cnt, 0);
        drive(0, 0, 0, 1, 32'h100); tick(); drive(0, 0, 0, 0, 0);
        check("flush_pulse", bus.flush, 1);
        check("flush_pc", bus.new_pc, 32'h100);
        check("flush_busy", bus.busy, 1);
        for (int i = 0; i < RC; i++) begin
            tick();
            check("refill_busy", bus.busy, 1);
            check("refill_flush", bus.flush, 0);
        end
        tick();
        check("idle_busy", bus.busy, 0);
        drive(0, 0, 0, 1, 32'h100); tick(); drive(0, 0, 0, 0, 0); tick(); tick();
        drive(0, 0, 0, 1, 32'h200); tick(); drive(0, 0, 0, 0, 0);
        check("reflush_pulse", bus.flush, 1);
        check("reflush_pc", bus.new_pc, 32'h200);
        for (int i = 0; i < RC; i++) begin
            tick();
            check("rerefill_busy", bus.busy, 1);
        end
        tick();
        check("reidle_busy", bus.busy, 0);
        drive(0, 0, 1, 1, 32'h300); #1 check("pre_flush_stall", bus.stall, 6'b011111);
        tick(); drive(0, 0, 1, 0, 0);
        check("flush_mask", bus.stall, 0);
        check("flush_cnt", bus.stall_cnt, 1);
        tick();
        check("refill_stall", bus.stall, 6'b011111);
        check("refill_cnt0", bus.stall_cnt, 0);
        tick();
        check("refill_cnt1", bus.stall_cnt, 1);
        drive(0, 0, 0, 0, 0);
        repeat (8) tick();
        drive(0, 1, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            check("to_cnt", bus.stall_cnt, (i > MAXC) ? MAXC : i);
            check("to_flag", bus.stall_timeout, i >= LIM);
        end
        drive(0, 0, 0, 0, 0); tick();
        check("to_release_cnt", bus.stall_cnt, 0);
        check("to_sticky", bus.stall_timeout, 1);
        rand_cycles(400);
        drive(0, 0, 0, 1, 32'h400); tick();
        drive(1, 0, 0, 0, 0); tick(); tick();
        #3 rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_flush", bus.flush, 0);
        check("arst_cnt", bus.stall_cnt, 0);
        check("arst_timeout", bus.stall_timeout, 0);
        check("arst_new_pc", bus.new_pc, 0);
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        tick();
        check("post_rst_busy", bus.busy, 0);
        rand_cycles(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It merges stall requests from the ID, EX and MEM stages into one per-stage stall vector that drives the PC register and every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB). It also sequences pipeline flushes through a small flush/refill state machine and raises a sticky timeout when a stall persists too long.

## Interface
- STALL_LIMIT, 255: number of consecutive stalled cycles at which `stall_timeout` sets.
- CNT_W, 8: width of the stall counter; the counter must be able to hold STALL_LIMIT.
- REFILL_CYCLES, 4: number of cycles spent in REFILL after a flush.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- stallreq_id  input  1  ID stage requests a stall (load-use hazard).
- stallreq_ex  input  1  EX stage requests a stall (multi-cycle operation).
- stallreq_mem  input  1  MEM stage requests a stall (memory wait).
- flush_req  input  1  request to flush the pipeline; sampled on the clock edge.
- flush_pc  input  32  restart address; captured with `flush_req`.
- stall  output  6  per-stage hold: bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 WB.
- flush  output  1  registered; clears all stage registers to NOP.
- new_pc  output  32  registered; restart address, valid while `flush`=1.
- busy  output  1  high while the state machine is in FLUSH or REFILL.
- stall_cnt  output  CNT_W  number of consecutive stalled cycles.
- stall_timeout  output  1  sticky; set when `stall_cnt` reaches STALL_LIMIT.

## Operation
- `stall` is combinational from the current requests and the current state. Highest-numbered stage wins:
  - `stallreq_mem` gives 6'b011111.
  - else `stallreq_ex` gives 6'b001111.
  - else `stallreq_id` gives 6'b000111.
  - else 6'b000000.
- In state FLUSH, `stall` is forced to 0.
- Contract with the stage registers:
  - When stall[k]=1 and stall[k+1]=0, the register downstream of stage k loads a bubble (NOP destination, write disabled, data zero).
  - When stall[k]=1, register k holds its contents.
- State machine states: IDLE, FLUSH, REFILL.
  - IDLE: on `flush_req`=1, go to FLUSH and capture `flush_pc` into `new_pc`.
  - FLUSH: lasts exactly one cycle; `flush`=1. Next state is REFILL with the refill counter loaded to REFILL_CYCLES-1.
  - REFILL: decrement the counter each cycle; go to IDLE when the counter is 0. Stall requests are honoured in REFILL.
- `flush_req` has priority in every state. If it is sampled in FLUSH or REFILL, the machine re-enters FLUSH with the new `flush_pc` (latest request wins) and the refill count restarts.
- `busy` = (state != IDLE). `flush` = (state == FLUSH).
- Stall counter:
  - Increments each cycle in which `stall` != 0.
  - Saturates at 2^CNT_W-1.
  - Clears to 0 on any cycle in which `stall` == 0, including FLUSH.
- `stall_timeout` sets on the edge where `stall_cnt` becomes STALL_LIMIT. It stays set until `rst`.

## Timing
- Reset values: state IDLE, `flush`=0, `new_pc`=32'h0, `busy`=0, `stall_cnt`=0, `stall_timeout`=0, refill counter 0.
- With all stall requests low, `stall`=0 immediately after reset.
- `rst` asserted mid-operation (FLUSH or REFILL) returns the block to IDLE asynchronously. No flush pulse completes.
- Stall path has zero latency: a request in cycle N produces `stall` in cycle N.
- Flush latency is one cycle. With `flush_req` high before edge N:
  - `flush`=1 and `new_pc` valid in cycle N (after edge N), for exactly one cycle.
  - `busy` is high from cycle N through cycle N+REFILL_CYCLES.
  - IDLE is reached at edge N+REFILL_CYCLES+1.
- A stall request in the same cycle as `flush`=1 is masked (`stall`=0) that cycle and takes effect the next cycle.
- Requests are level-sensitive. A stall request held across a flush is honoured again from the first REFILL cycle.
- Timeout: with a continuous stall starting at edge 1, `stall_cnt`=STALL_LIMIT after edge STALL_LIMIT, and `stall_timeout`=1 on that same edge.

## Test plan
- Reset with all requests 0 -> `stall`=0, `flush`=0, `busy`=0, `stall_cnt`=0, `new_pc`=0. Assert `rst` asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Drive `stallreq_id`, then `stallreq_ex`, then `stallreq_mem` one at a time, then all three together -> `stall` = 6'b000111, 6'b001111, 6'b011111, 6'b011111, each in the same cycle as its request.
- `flush_req`=1 with `flush_pc`=32'h0000_0100 for one cycle -> `flush`=1 and `new_pc`=32'h100 for one cycle, then `busy` stays high for 4 more cycles, then returns to IDLE.
- `flush_req` with 32'h100, then 32'h200 on the second REFILL cycle -> second `flush` pulse with `new_pc`=32'h200, and the refill count restarts at 4 cycles.
- Hold `stallreq_mem`=1 across a flush -> `stall`=0 in the `flush` cycle, `stall`=6'b011111 from the next cycle, and `stall_cnt` restarts from 1.
- STALL_LIMIT=10: hold `stallreq_ex` for 12 cycles -> `stall_timeout` rises after the 10th edge. Release the request -> `stall_cnt`=0 while `stall_timeout` stays 1 until `rst`.
